// File: rtl/renode_pkg.sv
// rtl/renode_pkg.sv - shared widths, FSM state type and helpers for the renode message arbiter
//
// Purpose : common definitions for renode_msg_arbiter and renode_rr_arbiter.
// Contents: message field widths, timeout counter width, arbiter FSM state
//           enum and a pointer-width helper that stays legal for one requester.

package renode_pkg;

    localparam int ACTION_W = 8;
    localparam int ADDR_W   = 64;
    localparam int DATA_W   = 64;
    localparam int TMO_W    = 16;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_SEND     = 2'd1,
        ST_WAIT_RSP = 2'd2
    } arb_state_t;

    // $clog2(1) is 0, which would give a zero-width pointer; keep at least one bit.
    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/renode_rr_arbiter.sv
// rtl/renode_rr_arbiter.sv - combinational round-robin grant selection
//
// Purpose : pick the first set request at or above ptr, wrapping to 0.
// Ports   : req   - request vector, one bit per requester
//           ptr   - search start index (always < N)
//           grant - one-hot grant, all zero when nothing is requested

module renode_rr_arbiter
    import renode_pkg::*;
#(
    parameter  int N    = 4,
    localparam int PtrW = ptr_width(N)
) (
    input  logic [N-1:0]    req,
    input  logic [PtrW-1:0] ptr,
    output logic [N-1:0]    grant
);

    logic found;

    // Two passes: first the indices from ptr upward, then the wrapped part
    // below ptr. The first hit in that order wins.
    always_comb begin
        grant = '0;
        found = 1'b0;
        for (int j = 0; j < N; j++) begin
            if (!found && req[j] && (j >= int'(ptr))) begin
                grant[j] = 1'b1;
                found    = 1'b1;
            end
        end
        for (int j = 0; j < N; j++) begin
            if (!found && req[j] && (j < int'(ptr))) begin
                grant[j] = 1'b1;
                found    = 1'b1;
            end
        end
    end

endmodule

// File: rtl/renode_msg_arbiter.sv
// rtl/renode_msg_arbiter.sv - round-robin message arbiter with response routing and timeout
//
// Purpose : funnels messages from RequestersCount requesters onto a single
//           connection, one outstanding message at a time, and routes the
//           response (or a timeout error) back to the owning requester.
// Ports   : clk, rst                 - clock, async active-high reset
//           req_valid/ready          - per-requester handshake (ready = one-hot grant in IDLE)
//           req_action/address/data  - per-requester packed message fields
//           req_needs_rsp            - per-requester "expects a response"
//           msg_valid/ready          - outgoing message handshake
//           msg_action/address/data  - outgoing message fields
//           rsp_valid/ready          - incoming response handshake
//           rsp_error, rsp_data      - incoming response payload
//           req_rsp_valid            - one-hot response strobe to the owner
//           req_rsp_error/data       - routed response payload, shared
//           busy                     - FSM not in IDLE
//           drop_count               - saturating count of stray responses

module renode_msg_arbiter
    import renode_pkg::*;
#(
    parameter int RequestersCount = 4,
    parameter int TimeoutCycles   = 1024
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [RequestersCount-1:0]          req_valid,
    output logic [RequestersCount-1:0]          req_ready,
    input  logic [RequestersCount*ACTION_W-1:0] req_action,
    input  logic [RequestersCount*ADDR_W-1:0]   req_address,
    input  logic [RequestersCount*DATA_W-1:0]   req_data,
    input  logic [RequestersCount-1:0]          req_needs_rsp,
    output logic                                msg_valid,
    input  logic                                msg_ready,
    output logic [ACTION_W-1:0]                 msg_action,
    output logic [ADDR_W-1:0]                   msg_address,
    output logic [DATA_W-1:0]                   msg_data,
    input  logic                                rsp_valid,
    output logic                                rsp_ready,
    input  logic                                rsp_error,
    input  logic [DATA_W-1:0]                   rsp_data,
    output logic [RequestersCount-1:0]          req_rsp_valid,
    output logic                                req_rsp_error,
    output logic [DATA_W-1:0]                   req_rsp_data,
    output logic                                busy,
    output logic [7:0]                          drop_count
);

    localparam int N     = RequestersCount;
    localparam int PTR_W = ptr_width(N);
    // Counter value at which the timeout fires; the strobe then lands exactly
    // TimeoutCycles cycles after entering WAIT_RSP.
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TimeoutCycles - 1);

    arb_state_t          state;
    logic [PTR_W-1:0]    rr_ptr;
    logic [PTR_W-1:0]    owner;
    logic                lat_needs_rsp;
    logic [TMO_W-1:0]    tmo_cnt;

    logic [N-1:0]        grant;
    logic [N-1:0]        owner_oh;
    logic [PTR_W-1:0]    grant_idx;
    logic [PTR_W-1:0]    next_ptr;
    logic [ACTION_W-1:0] sel_action;
    logic [ADDR_W-1:0]   sel_address;
    logic [DATA_W-1:0]   sel_data;
    logic                sel_needs_rsp;
    logic                req_hs;
    logic                rsp_hs;

    renode_rr_arbiter #(
        .N (N)
    ) u_rr (
        .req   (req_valid),
        .ptr   (rr_ptr),
        .grant (grant)
    );

    // Grant is one-hot, so an OR-mux over the packed request fields is enough.
    always_comb begin
        grant_idx     = '0;
        sel_action    = '0;
        sel_address   = '0;
        sel_data      = '0;
        sel_needs_rsp = 1'b0;
        owner_oh      = '0;
        for (int i = 0; i < N; i++) begin
            if (grant[i]) begin
                grant_idx     = PTR_W'(i);
                sel_action    = req_action[i*ACTION_W +: ACTION_W];
                sel_address   = req_address[i*ADDR_W +: ADDR_W];
                sel_data      = req_data[i*DATA_W +: DATA_W];
                sel_needs_rsp = req_needs_rsp[i];
            end
            owner_oh[i] = (owner == PTR_W'(i));
        end
    end

    assign next_ptr  = (grant_idx == PTR_W'(N - 1)) ? '0 : grant_idx + 1'b1;
    assign req_ready = (state == ST_IDLE) ? grant : '0;
    assign rsp_ready = (state != ST_SEND);
    assign busy      = (state != ST_IDLE);
    assign req_hs    = |(req_valid & req_ready);
    assign rsp_hs    = rsp_valid & rsp_ready;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= ST_IDLE;
            rr_ptr        <= '0;
            owner         <= '0;
            lat_needs_rsp <= 1'b0;
            tmo_cnt       <= '0;
            msg_valid     <= 1'b0;
            msg_action    <= '0;
            msg_address   <= '0;
            msg_data      <= '0;
            req_rsp_valid <= '0;
            req_rsp_error <= 1'b0;
            req_rsp_data  <= '0;
            drop_count    <= '0;
        end else begin
            // Strobe is a single-cycle pulse; payload registers hold.
            req_rsp_valid <= '0;
            case (state)
                ST_IDLE: begin
                    // Nothing is outstanding, so any response here is stray.
                    if (rsp_hs && (drop_count != 8'hFF)) begin
                        drop_count <= drop_count + 8'd1;
                    end
                    if (req_hs) begin
                        owner         <= grant_idx;
                        lat_needs_rsp <= sel_needs_rsp;
                        msg_action    <= sel_action;
                        msg_address   <= sel_address;
                        msg_data      <= sel_data;
                        msg_valid     <= 1'b1;
                        rr_ptr        <= next_ptr;
                        state         <= ST_SEND;
                    end
                end
                ST_SEND: begin
                    if (msg_ready) begin
                        msg_valid <= 1'b0;
                        tmo_cnt   <= '0;
                        state     <= lat_needs_rsp ? ST_WAIT_RSP : ST_IDLE;
                    end
                end
                ST_WAIT_RSP: begin
                    // A response in the firing cycle takes priority over the timeout.
                    if (rsp_valid) begin
                        req_rsp_valid <= owner_oh;
                        req_rsp_error <= rsp_error;
                        req_rsp_data  <= rsp_data;
                        state         <= ST_IDLE;
                    end else if ((TimeoutCycles != 0) && (tmo_cnt == TMO_LAST)) begin
                        req_rsp_valid <= owner_oh;
                        req_rsp_error <= 1'b1;
                        req_rsp_data  <= '0;
                        state         <= ST_IDLE;
                    end else if (TimeoutCycles != 0) begin
                        tmo_cnt <= tmo_cnt + 1'b1;
                    end
                end
                default: begin
                    msg_valid <= 1'b0;
                    state     <= ST_IDLE;
                end
            endcase
        end
    end

endmodule
